// File: rtl/asip_fetch_pkg.sv
// Shared types and constants for the RSA ASIP instruction-fetch front end.
package asip_fetch_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned PC_W   = 13;

    localparam logic [3:0]        HALT_OPCODE = 4'hF;
    localparam logic [WORD_W-1:0] NOP_WORD    = 16'h0000;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline boundary register: flush inserts a NOP bubble, load captures, otherwise hold.
module if_id_reg
    import asip_fetch_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               valid_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    // Flush wins over load; the PC is kept on flush since the bubble carries no address.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = INSTR_W'(NOP_WORD);
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = valid_in ? instr_in : INSTR_W'(NOP_WORD);
            pc_d    = pc_in;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= INSTR_W'(NOP_WORD);
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the 1-cycle synchronous imem and fills IF/ID.
module fetch_stage
    import asip_fetch_pkg::*;
#(
    parameter int unsigned ARQ              = 16,
    parameter int unsigned MEMORY_ADDR_SIZE = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pc_en,
    input  logic                        jenable,
    input  logic [MEMORY_ADDR_SIZE-1:0] jump_target,
    output logic [MEMORY_ADDR_SIZE-1:0] imem_addr,
    output logic                        imem_rd_en,
    input  logic [ARQ-1:0]              imem_rdata,
    output logic [ARQ-1:0]              instr_out,
    output logic [MEMORY_ADDR_SIZE-1:0] pc_out,
    output logic                        valid_out,
    output logic                        halted
);

    localparam logic [MEMORY_ADDR_SIZE-1:0] PC_ONE = MEMORY_ADDR_SIZE'(1);

    fetch_state_t                state_q, state_d;
    logic [MEMORY_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [MEMORY_ADDR_SIZE-1:0] fl_pc_q, fl_pc_d;
    logic                        fl_v_q, fl_v_d;
    logic                        halted_q, halted_d;
    logic                        ifid_load, ifid_flush;
    logic                        is_halt_word;

    assign is_halt_word = (imem_rdata[ARQ-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fl_pc_d    = fl_pc_q;
        fl_v_d     = fl_v_q;
        halted_d   = halted_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;

        // A stall re-issues the in-flight address so imem_rdata stays valid on resume.
        imem_addr  = (state_q == RUN && !pc_en && !jenable) ? fl_pc_q : pc_q;
        imem_rd_en = (state_q != HALT);

        if (state_q != HALT && jenable) begin
            ifid_flush = 1'b1;
            fl_v_d     = 1'b0;
            pc_d       = jump_target;
            state_d    = REDIRECT;
        end else begin
            unique case (state_q)
                BOOT: begin
                    fl_pc_d = pc_q;
                    fl_v_d  = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    state_d = RUN;
                end
                RUN: begin
                    if (pc_en) begin
                        ifid_load = 1'b1;
                        fl_pc_d   = pc_q;
                        fl_v_d    = 1'b1;
                        pc_d      = pc_q + PC_ONE;
                        if (fl_v_q && is_halt_word) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (pc_en) begin
                        fl_pc_d = pc_q;
                        fl_v_d  = 1'b1;
                        pc_d    = pc_q + PC_ONE;
                        state_d = RUN;
                    end
                end
                HALT: begin
                    ifid_flush = pc_en;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            pc_q     <= '0;
            fl_pc_q  <= '0;
            fl_v_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fl_pc_q  <= fl_pc_d;
            fl_v_q   <= fl_v_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .INSTR_W (ARQ),
        .ADDR_W  (MEMORY_ADDR_SIZE)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .instr_in  (imem_rdata),
        .pc_in     (fl_pc_q),
        .valid_in  (fl_v_q),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .valid_out (valid_out)
    );

    assign halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: synchronous imem model plus an expected-output queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        jenable;
    logic [12:0] jump_target;
    logic [12:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [12:0] pc_out;
    logic        valid_out;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic        halt_en   = 1'b0;
    logic [12:0] halt_addr = 13'd4;

    typedef struct packed {
        logic [15:0] instr;
        logic [12:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    fetch_stage #(
        .ARQ              (16),
        .MEMORY_ADDR_SIZE (13)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .jenable     (jenable),
        .jump_target (jump_target),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [12:0] a);
        if (halt_en && a == halt_addr) return 16'hF000;
        return 16'h1000 + {3'b000, a};
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pc(input logic [12:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            last = sb.pop_front();
            chk({tag, "_instr"}, 32'(instr_out), 32'(last.instr));
            chk({tag, "_pc"},    32'(pc_out),    32'(last.pc));
            chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_instr"},  32'(instr_out), 32'h0000);
        chk({tag, "_pc"},     32'(pc_out),    32'd0);
        chk({tag, "_valid"},  32'(valid_out), 32'd0);
        chk({tag, "_halted"}, 32'(halted),    32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        pc_en       = 1'b1;
        jenable     = 1'b0;
        jump_target = '0;

        // Reset state
        repeat (2) tick;
        chk_reset_outs("reset");
        chk("reset_rd_en", 32'(imem_rd_en), 32'd1);
        chk("reset_addr",  32'(imem_addr),  32'd0);

        // Free run from pc 0
        rst = 1'b1;
        for (int a = 0; a < 6; a++) push_pc(13'(a));
        tick;
        chk_bubble("boot");
        tick;
        pop_chk("run0");
        repeat (5) begin
            tick;
            pop_chk("run");
        end

        // Stall while 1005 is presented
        pc_en = 1'b0;
        repeat (3) begin
            tick;
            chk("stall_instr", 32'(instr_out), 32'h1005);
            chk("stall_pc",    32'(pc_out),    32'd5);
            chk("stall_valid", 32'(valid_out), 32'd1);
        end
        pc_en = 1'b1;
        push_pc(13'd6);
        push_pc(13'd7);
        tick;
        pop_chk("resume");
        tick;
        pop_chk("resume");

        // Redirect to 0x100: two bubbles then target
        jenable     = 1'b1;
        jump_target = 13'h0100;
        push_pc(13'h0100);
        push_pc(13'h0101);
        tick;
        chk_bubble("jmp_j1");
        jenable = 1'b0;
        tick;
        chk_bubble("jmp_j2");
        tick;
        pop_chk("jmp_j3");
        tick;
        pop_chk("jmp_j4");

        // PC wrap 8190 -> 8191 -> 0 -> 1
        jenable     = 1'b1;
        jump_target = 13'd8190;
        push_pc(13'd8190);
        push_pc(13'd8191);
        push_pc(13'd0);
        push_pc(13'd1);
        tick;
        chk_bubble("wrap_b1");
        jenable = 1'b0;
        tick;
        chk_bubble("wrap_b2");
        repeat (4) begin
            tick;
            pop_chk("wrap");
        end

        // HALT word at pc 4
        halt_en     = 1'b1;
        jenable     = 1'b1;
        jump_target = 13'd2;
        push_pc(13'd2);
        push_pc(13'd3);
        push_pc(13'd4);
        tick;
        chk_bubble("halt_b1");
        jenable = 1'b0;
        tick;
        chk_bubble("halt_b2");
        repeat (3) begin
            tick;
            pop_chk("halt_seq");
        end
        chk("halt_word", 32'(instr_out), 32'hF000);
        tick;
        chk("halted_set",   32'(halted),     32'd1);
        chk("halted_rd_en", 32'(imem_rd_en), 32'd0);
        chk("halted_valid", 32'(valid_out),  32'd0);
        jenable     = 1'b1;
        jump_target = 13'h0050;
        tick;
        jenable = 1'b0;
        repeat (2) tick;
        chk("halt_jmp_halted", 32'(halted),     32'd1);
        chk("halt_jmp_rd_en",  32'(imem_rd_en), 32'd0);
        chk("halt_jmp_valid",  32'(valid_out),  32'd0);

        // Asynchronous reset out of HALT, between edges
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("async_rst_halt");
        chk("sb_drained_1", 32'(sb.size()), 32'd0);
        halt_en = 1'b0;
        tick;
        rst = 1'b1;
        push_pc(13'd0);
        push_pc(13'd1);
        push_pc(13'd2);
        tick;
        chk_bubble("restart1_boot");
        repeat (3) begin
            tick;
            pop_chk("restart1");
        end

        // Asynchronous reset mid-stream
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("async_rst_run");
        chk("async_rst_addr", 32'(imem_addr), 32'd0);
        tick;
        rst = 1'b1;
        push_pc(13'd0);
        push_pc(13'd1);
        tick;
        chk_bubble("restart2_boot");
        repeat (2) begin
            tick;
            pop_chk("restart2");
        end
        chk("sb_drained_2", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
